// File: rtl/sonar_scheduler_pkg.sv
// sonar_scheduler_pkg
// Shared definitions for the sonar scheduler: controller state encoding,
// sensor-index width and the saturated ("no valid reading") distance value.
package sonar_scheduler_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_TRIG      = ST_TRIG,
    S_WAIT_RISE = ST_WAIT_RISE,
    S_MEASURE   = ST_MEASURE,
    S_GAP       = ST_GAP
  } state_t;

  // Sensor index width; supports up to 8 sensors.
  localparam int IDX_W = 3;

  // All-ones distance for a given width; also the timeout / stuck-echo marker.
  function automatic int dist_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int DIST_W_DEF = 9;
  localparam int DIST_MAX   = dist_max(DIST_W_DEF);

endpackage

// File: rtl/echo_sync.sv
// echo_sync
// Two-flop synchronizer for one asynchronous echo pin, followed by an edge
// register that produces single-cycle rise/fall pulses.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   din      : raw echo pin
//   level    : synchronized echo level
//   rise     : one-cycle pulse on a synchronized rising edge
//   fall     : one-cycle pulse on a synchronized falling edge
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s2d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s2d <= 1'b0;
    end else begin
      s1  <= din;
      s2  <= s1;
      s2d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s2d;
  assign fall  = ~s2 & s2d;

endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler
// Round-robin controller sharing one trigger/measure engine across
// NUM_SENSORS HC-SR04 class rangefinders. Fires one sensor at a time,
// measures its echo width in centimetres, enforces a hold-off gap between
// pings and publishes per-sensor distance, near and fault flags.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   echo       : raw echo pins (asynchronous)
//   enable     : per-sensor scan enable, sampled when a slot is selected
//   trig       : trigger pins, at most one high
//   dist_cm    : packed latest distances, sensor i at [i*DIST_W +: DIST_W]
//   near       : last reading below NEAR_CM and not a timeout
//   fault      : last reading timed out or echo was stuck high
//   valid      : one-cycle pulse when a result is written
//   valid_idx  : sensor index of the result flagged by valid
module sonar_scheduler
  import sonar_scheduler_pkg::*;
#(
  parameter int NUM_SENSORS    = 2,
  parameter int TRIG_CYCLES    = 1000,
  parameter int CM_CYCLES      = 5800,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int GAP_CYCLES     = 6000000,
  parameter int NEAR_CM        = 20,
  parameter int DIST_W         = DIST_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SENSORS-1:0]        echo,
  input  logic [NUM_SENSORS-1:0]        enable,
  output logic [NUM_SENSORS-1:0]        trig,
  output logic [NUM_SENSORS*DIST_W-1:0] dist_cm,
  output logic [NUM_SENSORS-1:0]        near,
  output logic [NUM_SENSORS-1:0]        fault,
  output logic                          valid,
  output logic [IDX_W-1:0]              valid_idx
);

  localparam int CNT_MAX_A = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int PRE_W     = $clog2(CM_CYCLES + 1);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CM_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [DIST_W-1:0] DMAX      = DIST_W'(dist_max(DIST_W));
  localparam logic [DIST_W-1:0] DIST_ONE  = DIST_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SENSORS - 1);

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == DMAX) ? v : v + DIST_ONE;
  endfunction

  // The falling-edge cycle itself is the Nth echo cycle, so a prescaler
  // sitting on its last count completes one more centimetre.
  function automatic logic [DIST_W-1:0] final_cm(input logic [PRE_W-1:0]  p,
                                                 input logic [DIST_W-1:0] c);
    return (p == PRE_LAST) ? sat_inc(c) : c;
  endfunction

  // Echo synchronizers, zero-extended to 8 so the 3-bit index fits exactly.
  logic [NUM_SENSORS-1:0] lvl, rise, fall;
  logic [7:0]             lvl_ext, rise_ext, fall_ext, en_ext;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sync
    echo_sync u_echo_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (echo[i]),
      .level (lvl[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign lvl_ext  = 8'(lvl);
  assign rise_ext = 8'(rise);
  assign fall_ext = 8'(fall);
  assign en_ext   = 8'(enable);

  state_t                 state, state_n;
  logic [IDX_W-1:0]       cur, cur_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [PRE_W-1:0]       pre, pre_n;
  logic [DIST_W-1:0]      cm, cm_n;
  logic [NUM_SENSORS-1:0] trig_n;
  logic                   wr_en, wr_near, wr_fault;
  logic [DIST_W-1:0]      wr_dist, meas_cm;
  logic                   found;
  logic [IDX_W-1:0]       sel, cand;

  // Next enabled sensor after cur, wrapping round-robin.
  always_comb begin
    found = 1'b0;
    sel   = cur;
    cand  = cur;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!found && en_ext[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign meas_cm = final_cm(pre, cm);

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    cnt_n    = cnt;
    pre_n    = pre;
    cm_n     = cm;
    wr_en    = 1'b0;
    wr_dist  = DMAX;
    wr_fault = 1'b1;
    wr_near  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (found) begin
          cur_n = sel;
          if (lvl_ext[sel]) begin
            // Echo already high before any trigger: report stuck sensor.
            wr_en   = 1'b1;
            state_n = S_GAP;
          end else begin
            state_n = S_TRIG;
          end
        end
      end
      S_TRIG: begin
        if (cnt == TRIG_LAST) begin
          cnt_n   = '0;
          state_n = S_WAIT_RISE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_WAIT_RISE: begin
        if (rise_ext[cur]) begin
          cnt_n   = '0;
          pre_n   = '0;
          cm_n    = '0;
          state_n = S_MEASURE;
        end else if (cnt == TO_LAST) begin
          wr_en   = 1'b1;
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_MEASURE: begin
        if (fall_ext[cur]) begin
          wr_en    = 1'b1;
          wr_dist  = meas_cm;
          wr_fault = 1'b0;
          wr_near  = (32'(meas_cm) < NEAR_CM);
          cnt_n    = '0;
          state_n  = S_GAP;
        end else if (cnt == TO_LAST) begin
          wr_en   = 1'b1;
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + CNT_ONE;
          if (pre == PRE_LAST) begin
            pre_n = '0;
            cm_n  = sat_inc(cm);
          end else begin
            pre_n = pre + PRE_ONE;
          end
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Trigger is registered alongside the state so it is glitch-free and
  // high for exactly the cycles spent in TRIG.
  always_comb begin
    trig_n = '0;
    for (int i = 0; i < NUM_SENSORS; i++)
      trig_n[i] = (state_n == S_TRIG) && (cur_n == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= LAST_IDX;
      cnt       <= '0;
      pre       <= '0;
      cm        <= '0;
      trig      <= '0;
      valid     <= 1'b0;
      valid_idx <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      cnt   <= cnt_n;
      pre   <= pre_n;
      cm    <= cm_n;
      trig  <= trig_n;
      valid <= wr_en;
      if (wr_en)
        valid_idx <= cur_n;
    end
  end

  // Per-sensor result registers; only the served sensor is updated.
  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_res
    logic [DIST_W-1:0] dist_q;
    logic              near_q, fault_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dist_q  <= DMAX;
        near_q  <= 1'b0;
        fault_q <= 1'b0;
      end else if (wr_en && (cur_n == IDX_W'(i))) begin
        dist_q  <= wr_dist;
        near_q  <= wr_near;
        fault_q <= wr_fault;
      end
    end

    assign dist_cm[i*DIST_W +: DIST_W] = dist_q;
    assign near[i]  = near_q;
    assign fault[i] = fault_q;
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler
// Scoreboard bench: a sensor responder answers each trigger with an echo and
// pushes the expected result; a monitor pops and compares on every valid.
module tb_sonar_scheduler;

  localparam int NS   = 2;
  localparam int TRIG = 10;
  localparam int CM   = 58;
  localparam int TO   = 2000;
  localparam int GAP  = 100;
  localparam int NEAR = 20;
  localparam int DW   = 9;
  localparam int DMAX = 511;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    echo, enable, trig, near, fault;
  logic [NS*DW-1:0] dist_cm;
  logic             valid;
  logic [2:0]       valid_idx;

  sonar_scheduler #(
    .NUM_SENSORS(NS), .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES(GAP), .NEAR_CM(NEAR), .DIST_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .enable(enable), .trig(trig),
    .dist_cm(dist_cm), .near(near), .fault(fault), .valid(valid),
    .valid_idx(valid_idx)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int idx;
    int lo;
    int hi;
    bit flt;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          results = 0;
  int          last_sel = NS - 1;
  int          twohot = 0;
  int          trig_rises[NS] = '{0, 0};
  int          mode[NS] = '{0, 0};    // 0 fixed width, 1 random, 2 silent, 3 overlong
  int          cfg_w[NS] = '{580, 580};
  logic [NS-1:0] stuck_mask = '0;
  logic [NS-1:0] echo_resp  = '0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dist_of(input int i);
    return int'(dist_cm[i*DW +: DW]);
  endfunction

  function automatic int next_en(input int last, input logic [NS-1:0] en);
    for (int k = 1; k <= NS; k++) begin
      int c;
      c = (last + k) % NS;
      if (en[c]) return c;
    end
    return -1;
  endfunction

  // Sensor responder: answers each completed trigger with an echo pulse
  // and records what the scheduler should report for it.
  initial begin
    logic [NS-1:0] prev_trig;
    int tlen[NS];
    int phase, dly, wid, ridx;
    prev_trig = '0;
    tlen = '{0, 0};
    phase = 0; dly = 0; wid = 0; ridx = 0;
    echo = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_trig = '0;
        tlen = '{0, 0};
        phase = 0;
        echo_resp = '0;
      end else begin
        if ($countones(trig) > 1) twohot++;
        if (phase == 1) begin
          dly--;
          if (dly == 0) begin
            echo_resp[ridx] = 1'b1;
            phase = 2;
          end
        end else if (phase == 2) begin
          wid--;
          if (wid == 0) begin
            echo_resp[ridx] = 1'b0;
            phase = 0;
          end
        end
        for (int i = 0; i < NS; i++) begin
          if (trig[i] && !prev_trig[i]) begin
            chk("rr_select", i, next_en(last_sel, enable));
            trig_rises[i]++;
          end
          if (trig[i]) tlen[i]++;
          if (!trig[i] && prev_trig[i]) begin
            exp_t e;
            int w;
            chk("trig_width", tlen[i], TRIG);
            tlen[i] = 0;
            e.idx = i;
            case (mode[i])
              1: w = $urandom_range(40, 1900);
              3: w = 2050;
              default: w = cfg_w[i];
            endcase
            if (mode[i] == 2 || w >= TO) begin
              e.lo = DMAX; e.hi = DMAX; e.flt = 1'b1;
            end else begin
              e.lo = (w - 1) / CM; e.hi = (w + 1) / CM; e.flt = 1'b0;
            end
            exp_q.push_back(e);
            if (mode[i] != 2) begin
              ridx  = i;
              dly   = $urandom_range(3, 60);
              wid   = w;
              phase = 1;
            end
          end
        end
        prev_trig = trig;
      end
      echo = echo_resp | stuck_mask;
    end
  end

  // Monitor: pops the oldest expectation on every valid pulse.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      last_sel = NS - 1;
    end else if (valid) begin
      results++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_idx", int'(valid_idx), -1);
      end else begin
        exp_t e;
        int d, en;
        e = exp_q.pop_front();
        chk("valid_idx", int'(valid_idx), e.idx);
        d = dist_of(e.idx);
        vectors++;
        if (d < e.lo || d > e.hi) begin
          miscompares++;
          $display("FAIL dist%0d: got %0d expected %0d..%0d at %0t", e.idx, d, e.lo, e.hi, $time);
        end
        chk("fault", int'(fault[e.idx]), int'(e.flt));
        if (e.flt) en = 0;
        else if (e.hi < NEAR) en = 1;
        else if (e.lo >= NEAR) en = 0;
        else en = (d < NEAR) ? 1 : 0;
        chk("near", int'(near[e.idx]), en);
        last_sel = e.idx;
      end
    end
  end

  task automatic wait_results(input int n, input int budget);
    int t0, c;
    t0 = results;
    c = 0;
    while (results < t0 + n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (results < t0 + n) chk("wait_results", results - t0, n);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_trig", int'(trig), 0);
    chk("rst_dist", int'(dist_cm), (1 << (NS*DW)) - 1);
    chk("rst_near", int'(near), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_valid_idx", int'(valid_idx), 0);
  endtask

  initial begin
    int base, c;
    rst = 1'b1;
    enable = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Single sensor, 580-cycle echo.
    mode = '{0, 0}; cfg_w = '{580, 580};
    enable = 2'b01;
    wait_results(2, 8000);
    chk("normal_dist0", dist_of(0), 10);
    chk("normal_near0", int'(near[0]), 1);
    chk("normal_fault0", int'(fault[0]), 0);

    // Round robin across both sensors.
    cfg_w = '{1160, 1769};
    enable = 2'b11;
    wait_results(4, 12000);
    chk("rr_dist0", dist_of(0), 20);
    chk("rr_near0", int'(near[0]), 0);
    chk("rr_dist1", dist_of(1), 30);

    // Sensor 1 never answers.
    mode[1] = 2;
    wait_results(4, 15000);
    chk("rise_to_dist1", dist_of(1), DMAX);
    chk("rise_to_fault1", int'(fault[1]), 1);
    chk("rise_to_near1", int'(near[1]), 0);

    // Scan disabled: no trigger activity at all.
    enable = 2'b00;
    repeat (3000) @(negedge clk);
    base = trig_rises[0] + trig_rises[1];
    repeat (10000) @(negedge clk);
    chk("disabled_trig_rises", trig_rises[0] + trig_rises[1], base);
    chk("disabled_dist0_kept", dist_of(0), 20);

    // Echo stuck high before selection.
    base = trig_rises[0];
    stuck_mask = 2'b01;
    repeat (5) @(negedge clk);
    begin
      exp_t e;
      e.idx = 0; e.lo = DMAX; e.hi = DMAX; e.flt = 1'b1;
      exp_q.push_back(e);
    end
    enable = 2'b01;
    wait_results(1, 20);
    enable = 2'b00;
    stuck_mask = 2'b00;
    chk("stuck_fault0", int'(fault[0]), 1);
    chk("stuck_no_trig0", trig_rises[0], base);
    repeat (200) @(negedge clk);

    // Clear enable[1] while sensor 1 is mid-measurement.
    mode = '{0, 0}; cfg_w = '{1160, 1769};
    enable = 2'b11;
    c = 0;
    while (!echo[1] && c < 10000) begin
      @(negedge clk);
      c++;
    end
    chk("echo1_started", int'(echo[1]), 1);
    repeat (500) @(negedge clk);
    enable = 2'b01;
    base = trig_rises[1];
    wait_results(4, 10000);
    chk("late_dist1", dist_of(1), 30);
    chk("late_fault1", int'(fault[1]), 0);
    chk("late_no_trig1", trig_rises[1], base);

    // Echo longer than the timeout.
    mode[0] = 3;
    wait_results(2, 8000);
    chk("meas_to_dist0", dist_of(0), DMAX);
    chk("meas_to_fault0", int'(fault[0]), 1);

    // Randomized widths and enable masks.
    mode = '{1, 1};
    enable = 2'b11;
    for (int k = 0; k < 8; k++) begin
      wait_results(1, 5000);
      enable = 2'($urandom_range(1, 3));
    end

    // Reset during the fifth cycle of a trigger pulse.
    enable = 2'b11;
    c = 0;
    while (trig == '0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("trig_seen", int'(trig != '0), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (trig == '0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("post_rst_first", int'(trig), 1);

    // Drain and final checks.
    enable = 2'b00;
    repeat (3000) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("trig_two_hot", twohot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
